rv32i_regs_sb: RTL and testbench

//  Next-generation RV32I integer register file: 2 async read ports, 2 sync write-back ports,

---
 rtl/rv32i_regs_sb.sv | 78 +++++++
 tb/tb_rv32i_regs_sb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_regs_sb.sv
// rv32i_regs_sb: RV32I register file with busy scoreboard; RV_REGS_BYPASS_EN enables same-cycle write-back forwarding
module rv32i_regs_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [AW-1:0]   rs1_reg,
   input  logic [AW-1:0]   rs2_reg,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_ready,
   output logic            rs2_ready,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic            wb0_enable,
   input  logic [AW-1:0]   wb0_reg,
   input  logic [XLEN-1:0] wb0_data,
   input  logic            wb1_enable,
   input  logic [AW-1:0]   wb1_reg,
   input  logic [XLEN-1:0] wb1_data,
   input  logic            flush,
   output logic [AW:0]     busy_count
);
   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy, busy_nxt;
   logic [AW:0]      count_nxt;
   // scoreboard next state: flush beats a new producer, which beats a completing write-back
   always_comb begin
      busy_nxt  = busy;
      count_nxt = '0;
      for (int r = 1; r < NREGS; r++) begin
         busy_nxt[r] = flush ? 1'b0 :
                       (issue_valid && issue_rd == AW'(r)) ? 1'b1 :
                       ((wb0_enable && wb0_reg == AW'(r)) || (wb1_enable && wb1_reg == AW'(r))) ? 1'b0 :
                       busy[r];
         count_nxt   = count_nxt + (AW+1)'(busy_nxt[r]);
      end
      busy_nxt[0] = 1'b0;
   end
   // architectural state: lane 1 overrides lane 0 on a shared destination; x0 never written
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
         busy       <= '0;
         busy_count <= '0;
      end else begin
         for (int r = 1; r < NREGS; r++)
            if (wb1_enable && wb1_reg == AW'(r)) regs[r] <= wb1_data;
            else if (wb0_enable && wb0_reg == AW'(r)) regs[r] <= wb0_data;
         busy       <= busy_nxt;
         busy_count <= count_nxt;
      end
   end
`ifdef RV_REGS_BYPASS_EN
   logic rs1_wb0, rs1_wb1, rs2_wb0, rs2_wb1;
   assign rs1_wb0 = wb0_enable && wb0_reg == rs1_reg && rs1_reg != '0;
   assign rs1_wb1 = wb1_enable && wb1_reg == rs1_reg && rs1_reg != '0;
   assign rs2_wb0 = wb0_enable && wb0_reg == rs2_reg && rs2_reg != '0;
   assign rs2_wb1 = wb1_enable && wb1_reg == rs2_reg && rs2_reg != '0;
   // read ports forward an in-flight write-back, lane 1 first
   always_comb begin
      rs1_data  = rs1_reg == '0 ? '0 : rs1_wb1 ? wb1_data : rs1_wb0 ? wb0_data : regs[rs1_reg];
      rs2_data  = rs2_reg == '0 ? '0 : rs2_wb1 ? wb1_data : rs2_wb0 ? wb0_data : regs[rs2_reg];
      rs1_ready = ~busy[rs1_reg] | rs1_wb0 | rs1_wb1;
      rs2_ready = ~busy[rs2_reg] | rs2_wb0 | rs2_wb1;
   end
`else
   // read ports reflect registered state only
   always_comb begin
      rs1_data  = rs1_reg == '0 ? '0 : regs[rs1_reg];
      rs2_data  = rs2_reg == '0 ? '0 : regs[rs2_reg];
      rs1_ready = ~busy[rs1_reg];
      rs2_ready = ~busy[rs2_reg];
   end
`endif
endmodule

// File: tb/tb_rv32i_regs_sb.sv
// tb_rv32i_regs_sb: randomized self-checking bench against a behavioural register-file model
module tb_rv32i_regs_sb;
   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  rs1_reg, rs2_reg, issue_rd, wb0_reg, wb1_reg;
   logic [31:0] rs1_data, rs2_data, wb0_data, wb1_data;
   logic        rs1_ready, rs2_ready, issue_valid, wb0_enable, wb1_enable, flush;
   logic [5:0]  busy_count;
   int          total = 0, bad = 0;
   logic [31:0] m_regs [32];
   bit          m_busy [32];

   rv32i_regs_sb dut (
      .clock(clock), .reset(reset),
      .rs1_reg(rs1_reg), .rs2_reg(rs2_reg),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .wb0_enable(wb0_enable), .wb0_reg(wb0_reg), .wb0_data(wb0_data),
      .wb1_enable(wb1_enable), .wb1_reg(wb1_reg), .wb1_data(wb1_data),
      .flush(flush), .busy_count(busy_count)
   );

   always #5 clock = ~clock;

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic logic [31:0] exp_data(input logic [4:0] r);
      if (r == 0) return 32'h0;
`ifdef RV_REGS_BYPASS_EN
      if (wb1_enable && wb1_reg == r) return wb1_data;
      if (wb0_enable && wb0_reg == r) return wb0_data;
`endif
      return m_regs[r];
   endfunction

   function automatic logic exp_ready(input logic [4:0] r);
      if (r == 0) return 1'b1;
`ifdef RV_REGS_BYPASS_EN
      if ((wb1_enable && wb1_reg == r) || (wb0_enable && wb0_reg == r)) return 1'b1;
`endif
      return !m_busy[r];
   endfunction

   task automatic idle();
      reset = 0; issue_valid = 0; issue_rd = 0; flush = 0;
      wb0_enable = 0; wb0_reg = 0; wb0_data = 0;
      wb1_enable = 0; wb1_reg = 0; wb1_data = 0;
   endtask

   task automatic tick();
      logic [31:0] nr [32];
      bit nb [32];
      nr = m_regs;
      nb = m_busy;
      if (reset) begin
         for (int i = 0; i < 32; i++) begin nr[i] = 0; nb[i] = 0; end
      end else begin
         if (wb0_enable && wb0_reg != 0) nr[wb0_reg] = wb0_data;
         if (wb1_enable && wb1_reg != 0) nr[wb1_reg] = wb1_data;
         if (flush) for (int i = 0; i < 32; i++) nb[i] = 0;
         else begin
            if (wb0_enable) nb[wb0_reg] = 0;
            if (wb1_enable) nb[wb1_reg] = 0;
            if (issue_valid && issue_rd != 0) nb[issue_rd] = 1;
         end
      end
      @(posedge clock);
      #1;
      m_regs = nr;
      m_busy = nb;
   endtask

   task automatic test_reset();
      idle(); reset = 1; rs1_reg = 5; rs2_reg = 0;
      tick(); tick();
      idle(); #1;
      total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL reset_rs1_data got=%h exp=0", rs1_data); end
      total++; if (rs1_ready !== 1'b1) begin bad++; $display("FAIL reset_rs1_ready got=%b exp=1", rs1_ready); end
      total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", busy_count); end
      wb0_enable = 1; wb0_reg = 5; wb0_data = 32'hDEADBEEF; issue_valid = 1; issue_rd = 7;
      tick();
      idle(); rs1_reg = 5; rs2_reg = 7; #1;
      total++; if (rs1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL pre_reset_x5 got=%h exp=deadbeef", rs1_data); end
      total++; if (rs2_ready !== 1'b0) begin bad++; $display("FAIL pre_reset_x7_ready got=%b exp=0", rs2_ready); end
      reset = 1; wb1_enable = 1; wb1_reg = 6; wb1_data = 32'h1; issue_valid = 1; issue_rd = 8;
      tick();
      idle(); rs1_reg = 5; rs2_reg = 7; #1;
      total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL midreset_x5 got=%h exp=0", rs1_data); end
      total++; if (rs2_ready !== 1'b1) begin bad++; $display("FAIL midreset_x7_ready got=%b exp=1", rs2_ready); end
      total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL midreset_count got=%0d exp=0", busy_count); end
   endtask

   task automatic test_x0();
      idle(); wb0_enable = 1; wb0_reg = 0; wb0_data = 32'h1234; issue_valid = 1; issue_rd = 0;
      tick();
      idle(); rs1_reg = 0; rs2_reg = 0; #1;
      total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL x0_data got=%h exp=0", rs1_data); end
      total++; if (rs1_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", rs1_ready); end
      total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL x0_count got=%0d exp=0", busy_count); end
   endtask

   task automatic test_same_reg();
      idle(); wb0_enable = 1; wb0_reg = 3; wb0_data = 32'hAAAA; wb1_enable = 1; wb1_reg = 3; wb1_data = 32'h5555;
      tick();
      idle(); rs1_reg = 3; #1;
      total++; if (rs1_data !== 32'h5555) begin bad++; $display("FAIL lane1_wins got=%h exp=5555", rs1_data); end
   endtask

   task automatic test_scoreboard();
      idle(); issue_valid = 1; issue_rd = 9;
      tick();
      idle(); rs2_reg = 9; #1;
      total++; if (rs2_ready !== 1'b0) begin bad++; $display("FAIL issue_ready got=%b exp=0", rs2_ready); end
      total++; if (busy_count !== 6'd1) begin bad++; $display("FAIL issue_count got=%0d exp=1", busy_count); end
      wb1_enable = 1; wb1_reg = 9; wb1_data = 32'h77;
      tick();
      idle(); rs2_reg = 9; #1;
      total++; if (rs2_ready !== 1'b1) begin bad++; $display("FAIL wb_ready got=%b exp=1", rs2_ready); end
      total++; if (rs2_data !== 32'h77) begin bad++; $display("FAIL wb_data got=%h exp=77", rs2_data); end
      total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL wb_count got=%0d exp=0", busy_count); end
      issue_valid = 1; issue_rd = 9; wb0_enable = 1; wb0_reg = 9; wb0_data = 32'h88;
      tick();
      idle(); rs2_reg = 9; #1;
      total++; if (rs2_ready !== 1'b0) begin bad++; $display("FAIL issue_wb_ready got=%b exp=0", rs2_ready); end
      total++; if (busy_count !== 6'd1) begin bad++; $display("FAIL issue_wb_count got=%0d exp=1", busy_count); end
      total++; if (rs2_data !== 32'h88) begin bad++; $display("FAIL issue_wb_data got=%h exp=88", rs2_data); end
      wb0_enable = 1; wb0_reg = 9; wb0_data = 32'h99;
      tick();
      idle();
   endtask

   task automatic test_flush();
      for (int r = 1; r <= 3; r++) begin
         idle(); issue_valid = 1; issue_rd = 5'(r);
         tick();
      end
      idle(); #1;
      total++; if (busy_count !== 6'd3) begin bad++; $display("FAIL three_busy_count got=%0d exp=3", busy_count); end
      flush = 1; wb0_enable = 1; wb0_reg = 2; wb0_data = 32'h42;
      tick();
      idle(); rs1_reg = 2; rs2_reg = 1; #1;
      total++; if (busy_count !== 6'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", busy_count); end
      total++; if (rs1_data !== 32'h42) begin bad++; $display("FAIL flush_wb_data got=%h exp=42", rs1_data); end
      total++; if (rs1_ready !== 1'b1 || rs2_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b%b exp=11", rs1_ready, rs2_ready); end
   endtask

   task automatic test_bypass();
      logic [31:0] old;
      idle(); issue_valid = 1; issue_rd = 4;
      tick();
      old = m_regs[4];
      idle(); rs1_reg = 4; wb0_enable = 1; wb0_reg = 4; wb0_data = 32'hCAFE; #1;
`ifdef RV_REGS_BYPASS_EN
      total++; if (rs1_data !== 32'hCAFE) begin bad++; $display("FAIL bypass_data got=%h exp=cafe", rs1_data); end
      total++; if (rs1_ready !== 1'b1) begin bad++; $display("FAIL bypass_ready got=%b exp=1", rs1_ready); end
`else
      total++; if (rs1_data !== old) begin bad++; $display("FAIL nobypass_data got=%h exp=%h", rs1_data, old); end
      total++; if (rs1_ready !== 1'b0) begin bad++; $display("FAIL nobypass_ready got=%b exp=0", rs1_ready); end
`endif
      tick();
      idle(); rs1_reg = 4; #1;
      total++; if (rs1_data !== 32'hCAFE) begin bad++; $display("FAIL bypass_next_data got=%h exp=cafe", rs1_data); end
      total++; if (rs1_ready !== 1'b1) begin bad++; $display("FAIL bypass_next_ready got=%b exp=1", rs1_ready); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         reset       = ($urandom_range(0, 99) == 0);
         flush       = ($urandom_range(0, 24) == 0);
         issue_valid = $urandom_range(0, 1) == 1;
         issue_rd    = 5'($urandom);
         wb0_enable  = $urandom_range(0, 2) != 0;
         wb0_reg     = 5'($urandom_range(0, 3) == 0 ? issue_rd : $urandom);
         wb0_data    = $urandom;
         wb1_enable  = $urandom_range(0, 2) != 0;
         wb1_reg     = 5'($urandom_range(0, 3) == 0 ? wb0_reg : $urandom);
         wb1_data    = $urandom;
         rs1_reg     = 5'($urandom_range(0, 2) == 0 ? wb0_reg : $urandom);
         rs2_reg     = 5'($urandom_range(0, 2) == 0 ? wb1_reg : $urandom);
         #1;
         total++; if (rs1_data !== exp_data(rs1_reg)) begin bad++; $display("FAIL rnd_rs1_data c=%0d r=%0d got=%h exp=%h", c, rs1_reg, rs1_data, exp_data(rs1_reg)); end
         total++; if (rs2_data !== exp_data(rs2_reg)) begin bad++; $display("FAIL rnd_rs2_data c=%0d r=%0d got=%h exp=%h", c, rs2_reg, rs2_data, exp_data(rs2_reg)); end
         total++; if (rs1_ready !== exp_ready(rs1_reg)) begin bad++; $display("FAIL rnd_rs1_ready c=%0d r=%0d got=%b exp=%b", c, rs1_reg, rs1_ready, exp_ready(rs1_reg)); end
         total++; if (rs2_ready !== exp_ready(rs2_reg)) begin bad++; $display("FAIL rnd_rs2_ready c=%0d r=%0d got=%b exp=%b", c, rs2_reg, rs2_ready, exp_ready(rs2_reg)); end
         total++; if (int'(busy_count) != m_count()) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, busy_count, m_count()); end
         tick();
      end
      idle();
   endtask

   initial begin
      idle(); rs1_reg = 0; rs2_reg = 0;
      for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
      test_reset();
      test_x0();
      test_same_reg();
      test_scoreboard();
      test_flush();
      test_bypass();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
